program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/pc_pkg.sv | 21 ++
 rtl/program_counter_if.sv | 23 ++
 rtl/pc_stack.sv | 51 +++++
 rtl/program_counter.sv | 115 +++++++++++
 tb/tb_program_counter.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter block.
//   PC_W          : program counter / address width
//   CMD_*         : per-cycle command codes after priority resolution
//   sp_width()    : stack-pointer width for a given return-stack depth
package pc_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_HOLD = 3'd0;
  localparam logic [CMD_W-1:0] CMD_INC  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LD   = 3'd2;
  localparam logic [CMD_W-1:0] CMD_CALL = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RET  = 3'd4;

  // Pointer must represent 0..depth inclusive, hence one extra bit.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Command/status bundle between the sequencer (master) and the PC (slave).
//   inc, ld, call, ret, target : commands and jump/call destination
//   PC                         : registered program counter
//   stk_full, stk_empty        : return-stack occupancy (combinational)
//   err                        : sticky stack overflow/underflow flag
interface program_counter_if;
  import pc_pkg::*;

  logic            inc;
  logic            ld;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] PC;
  logic            stk_full;
  logic            stk_empty;
  logic            err;

  modport master (output inc, ld, call, ret, target,
                  input  PC, stk_full, stk_empty, err);
  modport slave  (input  inc, ld, call, ret, target,
                  output PC, stk_full, stk_empty, err);
endinterface

// File: rtl/pc_stack.sv
// Return-address LIFO.
//   clk, rst   : clock, synchronous active-high reset (clears pointer only)
//   push, pop  : ignored when full / empty respectively
//   push_data  : value stored on push
//   top_data   : most recently pushed entry (undefined when empty)
//   full/empty : occupancy flags, combinational from the pointer
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = PC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned SP_W  = sp_width(DEPTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);
  assign top_data = mem[IDX_W'(sp - SP_W'(1))];

  // Stack pointer: saturating, never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage has no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[IDX_W'(sp)] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Program counter with optional return-address stack.
//   clk : clock          rst : synchronous active-high reset
//   bus : program_counter_if.slave (commands in, PC/status out)
// Build option: define PC_STACK_EN to compile in the call/return stack;
// without it call acts as ld, ret is ignored and status is constant.
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned     STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  program_counter_if.slave bus
);

  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic             err_q, err_nxt;
  logic [CMD_W-1:0] cmd;

  assign bus.PC  = pc_q;
  assign bus.err = err_q;

`ifdef PC_STACK_EN
  logic            push, pop, full, empty;
  logic [PC_W-1:0] top_data;

  // Priority: ret > call > ld > inc > hold.
  always_comb begin
    cmd = CMD_HOLD;
    if (bus.ret)       cmd = CMD_RET;
    else if (bus.call) cmd = CMD_CALL;
    else if (bus.ld)   cmd = CMD_LD;
    else if (bus.inc)  cmd = CMD_INC;
  end

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + PC_W'(1)),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty)
  );

  // Next PC, stack strobes and sticky error.
  always_comb begin
    pc_nxt  = pc_q;
    err_nxt = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (cmd)
      CMD_RET: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_nxt = top_data;
        end
      end
      CMD_CALL: begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push   = 1'b1;
          pc_nxt = bus.target;
        end
      end
      CMD_LD:  pc_nxt = bus.target;
      CMD_INC: pc_nxt = pc_q + PC_W'(1);
      default: ;
    endcase
  end

  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
`else
  // Without a stack, call is a plain jump and ret is dropped.
  always_comb begin
    cmd = CMD_HOLD;
    if (bus.call || bus.ld) cmd = CMD_LD;
    else if (bus.inc)       cmd = CMD_INC;
  end

  always_comb begin
    pc_nxt  = pc_q;
    err_nxt = 1'b0;
    case (cmd)
      CMD_LD:  pc_nxt = bus.target;
      CMD_INC: pc_nxt = pc_q + PC_W'(1);
      default: ;
    endcase
  end

  assign bus.stk_full  = 1'b0;
  assign bus.stk_empty = 1'b1;
`endif

  // State registers; reset overrides every command.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      err_q <= err_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// random commands, compared against a queue-based reference model.
module tb_program_counter;
  localparam int DEPTH = 4;
  localparam int RV    = 0;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_err;

  program_counter_if bus ();

  program_counter #(
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (8'(RV))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the specification's command rules to the model.
  task automatic model(input bit r, input bit i, input bit l, input bit c,
                       input bit t, input int tgt);
    if (r) begin
      m_pc  = RV;
      m_err = 0;
      m_stk.delete();
    end else begin
`ifdef PC_STACK_EN
      if (t) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else                  m_err = 1;
      end else if (c) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % 256);
          m_pc = tgt;
        end else m_err = 1;
      end else if (l) m_pc = tgt;
      else if (i)     m_pc = (m_pc + 1) % 256;
`else
      if (c || l)  m_pc = tgt;
      else if (i)  m_pc = (m_pc + 1) % 256;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},  32'(bus.PC), 32'(m_pc));
    check({tag, ".err"}, 32'(bus.err), 32'(m_err));
`ifdef PC_STACK_EN
    check({tag, ".full"},  32'(bus.stk_full),  32'(m_stk.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.stk_empty), 32'(m_stk.size() == 0));
`else
    check({tag, ".full"},  32'(bus.stk_full),  32'd0);
    check({tag, ".empty"}, 32'(bus.stk_empty), 32'd1);
`endif
  endtask

  task automatic step(input string tag, input bit r, input bit i, input bit l,
                      input bit c, input bit t, input int tgt);
    @(negedge clk);
    rst = r; bus.inc = i; bus.ld = l; bus.call = c; bus.ret = t;
    bus.target = 8'(tgt);
    @(posedge clk);
    model(r, i, l, c, t, tgt);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; bus.inc = 0; bus.ld = 0; bus.call = 0; bus.ret = 0; bus.target = '0;
    m_pc = 0; m_err = 0;

    // Reset then three increments.
    step("reset", 1, 0, 0, 0, 0, 0);
    check("reset_vec", 32'(bus.PC), 32'(RV));
    for (int k = 0; k < 3; k++) step("inc", 0, 1, 0, 0, 0, 0);
    check("inc3", 32'(bus.PC), 32'h03);

    // Wrap at 8'hFF.
    step("ld_ff", 0, 0, 1, 0, 0, 8'hFF);
    step("wrap", 0, 1, 0, 0, 0, 0);
    check("wrap_val", 32'(bus.PC), 32'h00);

    // Hold with no command.
    step("ld_77", 0, 0, 1, 0, 0, 8'h77);
    step("hold", 0, 0, 0, 0, 0, 0);

    // Nested calls/returns from PC=10.
    step("ld_10", 0, 0, 1, 0, 0, 8'h10);
    step("call40", 0, 0, 0, 1, 0, 8'h40);
    step("call80", 0, 0, 0, 1, 0, 8'h80);
    step("ret1", 0, 0, 0, 0, 1, 0);
    step("ret2", 0, 0, 0, 0, 1, 0);
`ifdef PC_STACK_EN
    check("nest_pc", 32'(bus.PC), 32'h11);
`else
    check("nest_pc", 32'(bus.PC), 32'h80);
`endif

    // Overflow: five calls at depth 4, then a ret.
    step("rst2", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("call_n", 0, 0, 0, 1, 0, 8'h20 + k);
    step("ret_after_ovf", 0, 0, 0, 0, 1, 0);

    // ld+inc together; ret+call on an empty stack.
    step("rst3", 1, 0, 0, 0, 0, 0);
    step("ld_inc", 0, 1, 1, 0, 0, 8'h55);
    check("ld_inc_val", 32'(bus.PC), 32'h55);
    step("ret_call_empty", 0, 0, 0, 1, 1, 8'h33);
    step("sticky", 0, 1, 0, 0, 0, 0);

    // Reset mid-operation overrides ret.
    step("call_pre", 0, 0, 0, 1, 0, 8'h20);
    step("rst_ret", 1, 0, 0, 0, 1, 0);
    check("rst_ret_pc", 32'(bus.PC), 32'(RV));
    step("call20", 0, 0, 0, 1, 0, 8'h20);
    check("call20_pc", 32'(bus.PC), 32'h20);
    step("ret_post", 0, 0, 0, 0, 1, 0);

    // Random commands against the model.
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
